// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//
// Debounces a raw, asynchronous push-button input. The input is brought into
// the clk domain through a 2-flop synchronizer. A 4-state FSM then accepts a
// level change only after DEBOUNCE_CYCLES consecutive stable samples beyond
// the first differing one.
//
// Optional feature (compile-time macro BUTTON_REPEAT_EN):
//   While the button is held, rise_pulse also fires as an auto-repeat pulse.
//   The first repeat pulse comes REPEAT_DELAY cycles after the press pulse,
//   and later pulses come every REPEAT_PERIOD cycles. Without the macro,
//   REPEAT_DELAY and REPEAT_PERIOD have no effect.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable samples needed to accept a change  (1..65535)
//   REPEAT_DELAY     held cycles before the first repeat pulse  (1..65535)
//   REPEAT_PERIOD    cycles between later repeat pulses         (1..65535)
//
// Ports:
//   clk         in   sole clock, rising-edge active
//   reset       in   synchronous, active-high reset
//   btn_raw     in   raw, asynchronous, bouncing button input
//   btn_level   out  debounced button level (registered)
//   rise_pulse  out  one-cycle press pulse, plus repeat pulses if enabled
//   fall_pulse  out  one-cycle release pulse
//   busy        out  high while a debounce qualification is in progress
// ---------------------------------------------------------------------------
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 10,
  parameter int unsigned REPEAT_PERIOD   = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    HELD_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_e;

  // cnt holds the last value before acceptance, so the compare uses N-1.
  localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic        sync0_q, sync0_d;
  logic        sync1_q, sync1_d;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        btn_level_q, btn_level_d;
  logic        rise_pulse_q, rise_pulse_d;
  logic        fall_pulse_q, fall_pulse_d;
  logic        busy_q, busy_d;
  logic [15:0] cnt_inc;

`ifdef BUTTON_REPEAT_EN
  localparam logic [15:0] DELAY_LAST  = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] PERIOD_LAST = 16'(REPEAT_PERIOD - 1);
  // Set until the first repeat pulse fires, so the initial delay is used once.
  logic        first_rep_q, first_rep_d;
  logic [15:0] rep_last;
  assign rep_last = first_rep_q ? DELAY_LAST : PERIOD_LAST;
`else
  // The repeat timing parameters are intentionally unused in this build.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{16'(REPEAT_DELAY), 16'(REPEAT_PERIOD)};
`endif

  // The counter saturates instead of wrapping, so a stuck state cannot alias.
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);

  always_comb begin
    sync0_d      = btn_raw;
    sync1_d      = sync0_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    btn_level_d  = btn_level_q;
    rise_pulse_d = 1'b0;
    fall_pulse_d = 1'b0;
`ifdef BUTTON_REPEAT_EN
    first_rep_d  = first_rep_q;
`endif
    case (state_q)
      IDLE_LOW: begin
        if (sync1_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = 16'd0;
        end else begin
          state_d = IDLE_LOW;
        end
      end
      WAIT_HIGH: begin
        if (!sync1_q) begin
          state_d = IDLE_LOW;          // bounce rejected, no pulse
        end else if (cnt_q == DEB_LAST) begin
          state_d      = HELD_HIGH;
          btn_level_d  = 1'b1;
          rise_pulse_d = 1'b1;
          cnt_d        = 16'd0;        // restart as the held-cycle counter
`ifdef BUTTON_REPEAT_EN
          first_rep_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD_HIGH: begin
        if (!sync1_q) begin
          state_d = WAIT_LOW;
          cnt_d   = 16'd0;
        end else begin
`ifdef BUTTON_REPEAT_EN
          if (cnt_q == rep_last) begin
            rise_pulse_d = 1'b1;
            cnt_d        = 16'd0;
            first_rep_d  = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
`else
          cnt_d = cnt_q;
`endif
        end
      end
      WAIT_LOW: begin
        if (sync1_q) begin
          // Bounce back to held: a later repeat waits a full period.
          state_d = HELD_HIGH;
          cnt_d   = 16'd0;
`ifdef BUTTON_REPEAT_EN
          first_rep_d = 1'b0;
`endif
        end else if (cnt_q == DEB_LAST) begin
          state_d      = IDLE_LOW;
          btn_level_d  = 1'b0;
          fall_pulse_d = 1'b1;
          cnt_d        = 16'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = 16'd0;
      end
    endcase
    // busy is registered, so it is derived from the next state.
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0_q      <= 1'b0;
      sync1_q      <= 1'b0;
      state_q      <= IDLE_LOW;
      cnt_q        <= 16'd0;
      btn_level_q  <= 1'b0;
      rise_pulse_q <= 1'b0;
      fall_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef BUTTON_REPEAT_EN
      first_rep_q  <= 1'b0;
`endif
    end else begin
      sync0_q      <= sync0_d;
      sync1_q      <= sync1_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      btn_level_q  <= btn_level_d;
      rise_pulse_q <= rise_pulse_d;
      fall_pulse_q <= fall_pulse_d;
      busy_q       <= busy_d;
`ifdef BUTTON_REPEAT_EN
      first_rep_q  <= first_rep_d;
`endif
    end
  end

  assign btn_level  = btn_level_q;
  assign rise_pulse = rise_pulse_q;
  assign fall_pulse = fall_pulse_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
// ---------------------------------------------------------------------------
// tb_button_debouncer
//
// Self-checking bench for button_debouncer with default parameters. It has
// two kinds of checks:
//   - Directed scenarios compare against the documented edge timelines.
//   - A run-length reference model predicts every output on every cycle.
// Honours BUTTON_REPEAT_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_button_debouncer;

  localparam int DEB  = 4;
  localparam int RDLY = 10;
  localparam int RPER = 5;
`ifdef BUTTON_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic btn_raw;
  logic btn_level, rise_pulse, fall_pulse, busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  // m_run counts consecutive synchronized samples that differ from the
  // accepted level. m_hold counts held cycles for the repeat timing.
  bit m_pipe0, m_pipe1;
  bit m_level, m_rise, m_fall, m_busy, m_first;
  int m_run, m_hold;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RDLY),
    .REPEAT_PERIOD(RPER)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance the reference model by one clock edge.
  function automatic void model_edge(input bit raw, input bit rst);
    bit s;
    if (rst) begin
      m_pipe0 = 0; m_pipe1 = 0; m_level = 0; m_rise = 0; m_fall = 0;
      m_busy = 0; m_first = 0; m_run = 0; m_hold = 0;
      return;
    end
    s = m_pipe1;
    m_pipe1 = m_pipe0;
    m_pipe0 = raw;
    m_rise = 0;
    m_fall = 0;
    if (s != m_level) begin
      m_run++;
      if (m_run == DEB + 1) begin
        m_level = s;
        m_run = 0;
        if (s) begin
          m_rise = 1; m_hold = 0; m_first = 1;
        end else begin
          m_fall = 1;
        end
      end
    end else begin
      if (m_level) begin
        if (m_run > 0) begin
          m_hold = 0; m_first = 0;     // bounced back during release
        end else begin
          m_hold++;
          if (REP && m_hold == (m_first ? RDLY : RPER)) begin
            m_rise = 1; m_hold = 0; m_first = 0;
          end
        end
      end
      m_run = 0;
    end
    m_busy = (m_run > 0);
  endfunction

  // Drive one cycle, update the model, and leave time to sample after the edge.
  task automatic step(input logic raw, input logic rst);
    btn_raw = raw;
    reset   = rst;
    @(posedge clk);
    model_edge(raw, rst);
    #1;
  endtask

  task automatic settle_low(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) begin
      step(i[0], 1'b1);
      vectors++;
      if ({btn_level, rise_pulse, fall_pulse, busy} !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset cyc%0d: got %b expected 0000", i,
                 {btn_level, rise_pulse, fall_pulse, busy});
      end
    end
    settle_low(4);
  endtask

  task automatic test_clean_press;
    logic [3:0] exp;
    settle_low(8);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      exp = {(i >= DEB + 2), (i == DEB + 2), 1'b0, (i >= 2 && i <= DEB + 1)};
      vectors++;
      if ({btn_level, rise_pulse, fall_pulse, busy} !== exp) begin
        miscompares++;
        $display("FAIL clean_press edge%0d: got %b expected %b", i,
                 {btn_level, rise_pulse, fall_pulse, busy}, exp);
      end
      vectors++;
      if ({btn_level, rise_pulse, fall_pulse, busy} !== {m_level, m_rise, m_fall, m_busy}) begin
        miscompares++;
        $display("FAIL clean_press_model edge%0d: got %b expected %b", i,
                 {btn_level, rise_pulse, fall_pulse, busy}, {m_level, m_rise, m_fall, m_busy});
      end
    end
  endtask

  // Runs while the button is still held from test_clean_press.
  task automatic test_release;
    logic [3:0] exp;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0);
      exp = {(i < DEB + 2), 1'b0, (i == DEB + 2), (i >= 2 && i <= DEB + 1)};
      vectors++;
      if ({btn_level, rise_pulse, fall_pulse, busy} !== exp) begin
        miscompares++;
        $display("FAIL release edge%0d: got %b expected %b", i,
                 {btn_level, rise_pulse, fall_pulse, busy}, exp);
      end
    end
  endtask

  task automatic test_bounce;
    logic raw;
    int rises, rise_at;
    settle_low(8);
    rises = 0; rise_at = -1;
    for (int i = 0; i < 16; i++) begin
      raw = (i < 3) || (i >= 5);
      step(raw, 1'b0);
      if (rise_pulse === 1'b1) begin rises++; rise_at = i; end
      vectors++;
      if ({btn_level, rise_pulse, fall_pulse, busy} !== {m_level, m_rise, m_fall, m_busy}) begin
        miscompares++;
        $display("FAIL bounce_model edge%0d: got %b expected %b", i,
                 {btn_level, rise_pulse, fall_pulse, busy}, {m_level, m_rise, m_fall, m_busy});
      end
    end
    vectors++;
    if (rises !== 1 || rise_at !== 5 + DEB + 2) begin
      miscompares++;
      $display("FAIL bounce_pulse: got %0d pulses at edge %0d expected 1 at edge %0d",
               rises, rise_at, 5 + DEB + 2);
    end
    settle_low(12);
  endtask

  task automatic test_reset_mid;
    int rise_at;
    settle_low(8);
    rise_at = -1;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, (i == 4));
      if (rise_pulse === 1'b1 && rise_at < 0) rise_at = i;
      if (i == 4) begin
        vectors++;
        if ({btn_level, rise_pulse, fall_pulse, busy} !== 4'b0000) begin
          miscompares++;
          $display("FAIL reset_mid_outputs: got %b expected 0000",
                   {btn_level, rise_pulse, fall_pulse, busy});
        end
      end
    end
    vectors++;
    if (rise_at !== 4 + 1 + DEB + 2) begin
      miscompares++;
      $display("FAIL reset_mid_requalify: got rise at edge %0d expected %0d",
               rise_at, 4 + 1 + DEB + 2);
    end
    settle_low(12);
  endtask

  task automatic test_glitch;
    int busy_seen, bad;
    settle_low(8);
    busy_seen = 0; bad = 0;
    for (int i = 0; i < 10; i++) begin
      step((i == 0), 1'b0);
      if (busy === 1'b1) busy_seen++;
      if ({btn_level, rise_pulse, fall_pulse} !== 3'b000) bad++;
    end
    vectors++;
    if (bad !== 0 || busy_seen !== 1) begin
      miscompares++;
      $display("FAIL glitch: got %0d bad cycles and busy high %0d cycles expected 0 and 1",
               bad, busy_seen);
    end
  endtask

  task automatic test_repeat;
    logic exp_rise;
    int off;
    settle_low(8);
    for (int i = 0; i <= DEB + 2 + 30; i++) begin
      step(1'b1, 1'b0);
      off = i - (DEB + 2);
      exp_rise = (off == 0) ||
                 (REP && off >= RDLY && ((off - RDLY) % RPER) == 0);
      vectors++;
      if (rise_pulse !== exp_rise) begin
        miscompares++;
        $display("FAIL repeat offset%0d: rise_pulse got %b expected %b", off, rise_pulse, exp_rise);
      end
    end
    settle_low(12);
  endtask

  task automatic test_random;
    logic raw;
    int run;
    raw = 1'b0; run = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run == 0) begin
        raw = ~raw;
        run = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 45) : $urandom_range(1, 7);
      end
      run--;
      step(raw, ($urandom_range(0, 199) == 0));
      vectors++;
      if ({btn_level, rise_pulse, fall_pulse, busy} !== {m_level, m_rise, m_fall, m_busy}) begin
        miscompares++;
        $display("FAIL random cyc%0d: got %b expected %b", i,
                 {btn_level, rise_pulse, fall_pulse, busy}, {m_level, m_rise, m_fall, m_busy});
      end
      vectors++;
      if (rise_pulse === 1'b1 && fall_pulse === 1'b1) begin
        miscompares++;
        $display("FAIL random_exclusive cyc%0d: got rise=1 fall=1 expected not both", i);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    btn_raw = 1'b0;
    model_edge(1'b0, 1'b1);
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_reset_mid();
    test_glitch();
    test_repeat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
